// File: rtl/alu_arbiter.sv
// Two-requester front end for a shared combinational ALU: grants one request at a time,
// holds the operands for the ALU, registers the result and presents it until it is accepted.
module alu_arbiter #(
  parameter logic FIRST_GRANT = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_valid,
  output logic [1:0] req_ready,
  input  logic [9:0] req_a,
  input  logic [9:0] req_b,
  input  logic [3:0] req_op,
  output logic [4:0] alu_a,
  output logic [4:0] alu_b,
  output logic [1:0] alu_opcode,
  input  logic [4:0] alu_result,
  input  logic       alu_overflow,
  input  logic       alu_illegal,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic       rsp_id,
  output logic [4:0] rsp_result,
  output logic       rsp_overflow,
  output logic       rsp_illegal,
  output logic       busy,
  output logic [3:0] illegal_cnt
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

  state_e     state_q, state_d;
  logic       last_grant_q;
  logic [4:0] a_q, b_q;
  logic [1:0] op_q;
  logic       id_q;
  logic       rsp_id_q, rsp_ovf_q, rsp_ill_q;
  logic [4:0] rsp_res_q;
  logic [3:0] ill_cnt_q;

  logic       gnt_id;
  logic       xfer;
  logic       rsp_accept;

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  // Alternate on contention; a lone requester always wins.
  always_comb begin
    gnt_id = 1'b0;
    unique case (req_valid)
      2'b01:   gnt_id = 1'b0;
      2'b10:   gnt_id = 1'b1;
      2'b11:   gnt_id = ~last_grant_q;
      default: gnt_id = 1'b0;
    endcase
  end

  // Ready is gated by rst_n so it drops the moment reset asserts.
  assign xfer       = rst_n && (state_q == IDLE) && (|req_valid);
  assign req_ready  = xfer ? (gnt_id ? 2'b10 : 2'b01) : 2'b00;
  assign rsp_accept = (state_q == RESP) && rsp_ready;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (|req_valid) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Stage 0: request capture into the operand registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= ~FIRST_GRANT;
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= '0;
      id_q         <= 1'b0;
    end else begin
      state_q <= state_d;
      if (xfer) begin
        last_grant_q <= gnt_id;
        id_q         <= gnt_id;
        a_q          <= gnt_id ? req_a[9:5] : req_a[4:0];
        b_q          <= gnt_id ? req_b[9:5] : req_b[4:0];
        op_q         <= gnt_id ? req_op[3:2] : req_op[1:0];
      end
    end
  end

  // Stage 1: ALU result capture and response bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_id_q  <= 1'b0;
      rsp_res_q <= '0;
      rsp_ovf_q <= 1'b0;
      rsp_ill_q <= 1'b0;
      ill_cnt_q <= '0;
    end else begin
      if (state_q == EXEC) begin
        rsp_id_q  <= id_q;
        rsp_res_q <= alu_result;
        rsp_ovf_q <= alu_overflow;
        rsp_ill_q <= alu_illegal;
      end
      if (rsp_accept && rsp_ill_q) ill_cnt_q <= sat_inc(ill_cnt_q);
    end
  end

  assign alu_a        = a_q;
  assign alu_b        = b_q;
  assign alu_opcode   = op_q;
  assign rsp_valid    = (state_q == RESP);
  assign rsp_id       = rsp_id_q;
  assign rsp_result   = rsp_res_q;
  assign rsp_overflow = rsp_ovf_q;
  assign rsp_illegal  = rsp_ill_q;
  assign busy         = (state_q != IDLE);
  assign illegal_cnt  = ill_cnt_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with an XOR ALU stub: table of single transactions
// plus hand sequences for contention, backpressure, illegal saturation and reset mid-flight.
module tb_alu_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] req_valid;
  logic [1:0] req_ready;
  logic [9:0] req_a, req_b;
  logic [3:0] req_op;
  logic [4:0] alu_a, alu_b, alu_result;
  logic [1:0] alu_opcode;
  logic       alu_overflow, alu_illegal;
  logic       rsp_valid, rsp_ready, rsp_id, rsp_overflow, rsp_illegal, busy;
  logic [4:0] rsp_result;
  logic [3:0] illegal_cnt;

  int nvec  = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  assign alu_result   = alu_a ^ alu_b;
  assign alu_overflow = alu_a[4] & alu_b[4];
  assign alu_illegal  = (alu_opcode == 2'b11);

  alu_arbiter #(.FIRST_GRANT(1'b0)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
    .alu_result(alu_result), .alu_overflow(alu_overflow), .alu_illegal(alu_illegal),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_overflow(rsp_overflow), .rsp_illegal(rsp_illegal),
    .busy(busy), .illegal_cnt(illegal_cnt)
  );

  typedef struct packed {
    logic [1:0] vld;
    logic [4:0] a;
    logic [4:0] b;
    logic [1:0] op;
    logic       gnt;
    logic [4:0] res;
    logic       ovf;
    logic       ill;
    logic [3:0] cnt;
  } vec_t;

  vec_t tbl [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset();
    chk("rst_req_ready", 32'(req_ready), 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_rsp_id", 32'(rsp_id), 32'h0);
    chk("rst_rsp_result", 32'(rsp_result), 32'h0);
    chk("rst_rsp_ovf", 32'(rsp_overflow), 32'h0);
    chk("rst_rsp_ill", 32'(rsp_illegal), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_ill_cnt", 32'(illegal_cnt), 32'h0);
    chk("rst_alu_a", 32'(alu_a), 32'h0);
    chk("rst_alu_b", 32'(alu_b), 32'h0);
    chk("rst_alu_op", 32'(alu_opcode), 32'h0);
  endtask

  // One complete request/response with rsp_ready held high; starts and ends in IDLE.
  task automatic do_txn(input vec_t v);
    req_valid = v.vld;
    req_a     = v.gnt ? {v.a, ~v.a} : {~v.a, v.a};
    req_b     = v.gnt ? {v.b, ~v.b} : {~v.b, v.b};
    req_op    = v.gnt ? {v.op, ~v.op} : {~v.op, v.op};
    rsp_ready = 1'b1;
    #1;
    chk("idle_ready", 32'(req_ready), v.gnt ? 32'h2 : 32'h1);
    chk("idle_busy", 32'(busy), 32'h0);
    step();
    req_valid = 2'b00;
    #1;
    chk("exec_busy", 32'(busy), 32'h1);
    chk("exec_ready", 32'(req_ready), 32'h0);
    chk("exec_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("exec_alu_a", 32'(alu_a), 32'(v.a));
    chk("exec_alu_b", 32'(alu_b), 32'(v.b));
    chk("exec_alu_op", 32'(alu_opcode), 32'(v.op));
    step();
    chk("resp_valid", 32'(rsp_valid), 32'h1);
    chk("resp_id", 32'(rsp_id), 32'(v.gnt));
    chk("resp_result", 32'(rsp_result), 32'(v.res));
    chk("resp_ovf", 32'(rsp_overflow), 32'(v.ovf));
    chk("resp_ill", 32'(rsp_illegal), 32'(v.ill));
    step();
    chk("done_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("done_busy", 32'(busy), 32'h0);
    chk("done_ill_cnt", 32'(illegal_cnt), 32'(v.cnt));
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #1;
    chk_reset();
    step();
    chk_reset();
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected end before %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    //         vld    a      b      op     gnt   res    ovf   ill   cnt
    tbl[0] = {2'b01, 5'h0A, 5'h05, 2'b00, 1'b0, 5'h0F, 1'b0, 1'b0, 4'd0};
    tbl[1] = {2'b10, 5'h1F, 5'h10, 2'b01, 1'b1, 5'h0F, 1'b1, 1'b0, 4'd0};
    tbl[2] = {2'b01, 5'h13, 5'h1C, 2'b11, 1'b0, 5'h0F, 1'b1, 1'b1, 4'd1};
    tbl[3] = {2'b10, 5'h00, 5'h00, 2'b10, 1'b1, 5'h00, 1'b0, 1'b0, 4'd1};
    tbl[4] = {2'b01, 5'h15, 5'h0A, 2'b01, 1'b0, 5'h1F, 1'b0, 1'b0, 4'd1};
    tbl[5] = {2'b10, 5'h08, 5'h08, 2'b11, 1'b1, 5'h00, 1'b0, 1'b1, 4'd2};

    rst_n = 1'b0; req_valid = 2'b11; req_a = '0; req_b = '0; req_op = '0; rsp_ready = 1'b0;
    step();
    chk_reset();
    step();
    rst_n = 1'b1; req_valid = 2'b00;
    step();

    foreach (tbl[i]) do_txn(tbl[i]);

    // Contention after a fresh reset: grants alternate starting with requester 0
    pulse_reset();
    req_valid = 2'b11; req_a = {5'h03, 5'h01}; req_b = {5'h04, 5'h02}; req_op = 4'b0000;
    rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("cont_ready", 32'(req_ready), k[0] ? 32'h2 : 32'h1);
      step();
      chk("cont_exec_busy", 32'(busy), 32'h1);
      step();
      chk("cont_rsp_valid", 32'(rsp_valid), 32'h1);
      chk("cont_rsp_id", 32'(rsp_id), 32'(k[0]));
      chk("cont_rsp_result", 32'(rsp_result), k[0] ? 32'h07 : 32'h03);
      step();
    end
    req_valid = 2'b00;
    #1;

    // Backpressure: response held for 5 cycles while both requesters wait
    req_valid = 2'b01; req_a = {5'h00, 5'h1A}; req_b = {5'h00, 5'h11}; req_op = 4'b0001;
    rsp_ready = 1'b0;
    #1;
    chk("bp_ready", 32'(req_ready), 32'h1);
    step();
    req_valid = 2'b11;
    step();
    for (int k = 0; k < 5; k++) begin
      chk("bp_rsp_valid", 32'(rsp_valid), 32'h1);
      chk("bp_rsp_id", 32'(rsp_id), 32'h0);
      chk("bp_rsp_result", 32'(rsp_result), 32'h0B);
      chk("bp_rsp_ovf", 32'(rsp_overflow), 32'h1);
      chk("bp_busy", 32'(busy), 32'h1);
      chk("bp_req_ready", 32'(req_ready), 32'h0);
      step();
    end
    rsp_ready = 1'b1;
    #1;
    chk("bp_accept_valid", 32'(rsp_valid), 32'h1);
    step();
    chk("bp_after_busy", 32'(busy), 32'h0);
    chk("bp_after_grant", 32'(req_ready), 32'h2);
    req_valid = 2'b00;
    #1;
    chk("drop_ready", 32'(req_ready), 32'h0);
    step();
    chk("drop_busy", 32'(busy), 32'h0);

    // Illegal opcode saturation: 17 illegal responses, counter stops at 15
    for (int i = 0; i < 17; i++) begin
      v = {(i % 2 == 1) ? 2'b10 : 2'b01, 5'h10, 5'h10, 2'b11, 1'(i % 2),
           5'h00, 1'b1, 1'b1, (i >= 14) ? 4'd15 : 4'(i + 1)};
      do_txn(v);
    end

    // Reset while in EXEC discards the operation
    req_valid = 2'b01; req_a = {5'h00, 5'h1F}; req_b = {5'h00, 5'h1F}; req_op = 4'b0011;
    rsp_ready = 1'b1;
    step();
    chk("rx_exec_busy", 32'(busy), 32'h1);
    req_valid = 2'b11;
    pulse_reset();
    req_valid = 2'b00;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("rx_no_rsp", 32'(rsp_valid), 32'h0);
      chk("rx_idle", 32'(busy), 32'h0);
    end
    v = {2'b10, 5'h0C, 5'h03, 2'b00, 1'b1, 5'h0F, 1'b0, 1'b0, 4'd0};
    do_txn(v);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
